// File: rtl/step_phase_decoder.sv
// Decodes the four coil-drive lines of a full-step motor into position, direction and step strobe.
// Optional idle/stall detector enabled with `define STEP_PHASE_STALL_DETECT_EN.
module step_phase_decoder #(
    parameter int unsigned POS_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
`ifdef STEP_PHASE_STALL_DETECT_EN
    ,
    parameter int unsigned STALL_CYC   = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             an,
    input  logic             b,
    input  logic             bn,
    input  logic             clr,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             energised,
    output logic             fault,
    output logic [1:0]       fault_code
`ifdef STEP_PHASE_STALL_DETECT_EN
    ,
    output logic             stall
`endif
);

    localparam int unsigned SS = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ILLEGAL = 2'b01;
    localparam logic [1:0] CODE_PAIR    = 2'b10;

    // Input synchronizer, one 4-bit word {a, an, b, bn} per stage
    logic [3:0] sync_q [SS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SS; i++) sync_q[i] <= 4'b0000;
        end else begin
            sync_q[0] <= {a, an, b, bn};
            for (int i = 1; i < SS; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic [3:0] smp;
    logic       smp_idle;
    logic       smp_valid;
    logic [1:0] cur_phase;

    assign smp       = sync_q[SS-1];
    assign smp_idle  = (smp == 4'b0000);
    assign smp_valid = (smp[3] ^ smp[2]) & (smp[1] ^ smp[0]);
    assign cur_phase = {smp[3], smp[1]};

    // Forward successor in the full-step Gray cycle 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] fwd_of(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    logic [1:0]       prev_phase, prev_phase_n;
    logic             ref_valid, ref_valid_n;
    logic [POS_W-1:0] pos_n;
    logic             dir_n, step_n, energised_n, fault_n;
    logic [1:0]       fault_code_n;
    logic             is_fwd, is_rev, is_illegal;

    assign is_fwd     = (cur_phase == fwd_of(prev_phase));
    assign is_rev     = (prev_phase == fwd_of(cur_phase));
    assign is_illegal = ((cur_phase ^ prev_phase) == 2'b11);

    // Next-state: classify the synchronized sample, then let clr override
    always_comb begin
        pos_n        = pos;
        dir_n        = dir;
        step_n       = 1'b0;
        energised_n  = energised;
        fault_n      = fault;
        fault_code_n = fault_code;
        prev_phase_n = prev_phase;
        ref_valid_n  = ref_valid;

        if (smp_idle) begin
            energised_n = 1'b0;
            ref_valid_n = 1'b0;
        end else if (smp_valid) begin
            energised_n  = 1'b1;
            prev_phase_n = cur_phase;
            ref_valid_n  = 1'b1;
            if (ref_valid) begin
                if (is_fwd) begin
                    pos_n  = pos + POS_W'(1);
                    dir_n  = 1'b1;
                    step_n = 1'b1;
                end else if (is_rev) begin
                    pos_n  = pos - POS_W'(1);
                    dir_n  = 1'b0;
                    step_n = 1'b1;
                end else if (is_illegal) begin
                    fault_n = 1'b1;
                    if (!fault) fault_code_n = CODE_ILLEGAL;
                end
            end
        end else begin
            energised_n = 1'b0;
            ref_valid_n = 1'b0;
            fault_n     = 1'b1;
            if (!fault) fault_code_n = CODE_PAIR;
        end

        if (clr) begin
            pos_n        = '0;
            dir_n        = dir;
            step_n       = 1'b0;
            fault_n      = 1'b0;
            fault_code_n = CODE_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos        <= '0;
            dir        <= 1'b0;
            step       <= 1'b0;
            energised  <= 1'b0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            prev_phase <= 2'b00;
            ref_valid  <= 1'b0;
        end else begin
            pos        <= pos_n;
            dir        <= dir_n;
            step       <= step_n;
            energised  <= energised_n;
            fault      <= fault_n;
            fault_code <= fault_code_n;
            prev_phase <= prev_phase_n;
            ref_valid  <= ref_valid_n;
        end
    end

`ifdef STEP_PHASE_STALL_DETECT_EN
    localparam int unsigned CNT_W = ($clog2(STALL_CYC + 1) < 1) ? 1 : $clog2(STALL_CYC + 1);

    logic [CNT_W-1:0] idle_cnt, idle_cnt_n;

    // Saturating count of energised cycles without a step
    always_comb begin
        idle_cnt_n = idle_cnt;
        if (clr || step || !energised) begin
            idle_cnt_n = '0;
        end else if (idle_cnt < CNT_W'(STALL_CYC)) begin
            idle_cnt_n = idle_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            idle_cnt <= idle_cnt_n;
            stall    <= (idle_cnt_n >= CNT_W'(STALL_CYC));
        end
    end
`endif

endmodule

// File: tb/tb_step_phase_decoder.sv
// Randomized and directed bench for step_phase_decoder against a phase-index reference model.
module tb_step_phase_decoder;

    localparam int unsigned POS_W     = 16;
    localparam int unsigned NS        = 2;
    localparam int unsigned STALL_CYC = 16;

    logic             clk;
    logic             rst;
    logic             a, an, b, bn, clr;
    logic [POS_W-1:0] pos;
    logic             dir, step, energised, fault;
    logic [1:0]       fault_code;
`ifdef STEP_PHASE_STALL_DETECT_EN
    logic             stall;
`endif

    step_phase_decoder #(
        .POS_W(POS_W),
        .SYNC_STAGES(NS)
`ifdef STEP_PHASE_STALL_DETECT_EN
        ,
        .STALL_CYC(STALL_CYC)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .an(an),
        .b(b),
        .bn(bn),
        .clr(clr),
        .pos(pos),
        .dir(dir),
        .step(step),
        .energised(energised),
        .fault(fault),
        .fault_code(fault_code)
`ifdef STEP_PHASE_STALL_DETECT_EN
        ,
        .stall(stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Position of each phase code {a,b} around the forward cycle, and the cycle itself
    int         gi[4]      = '{0, 3, 1, 2};
    logic [1:0] fwd_seq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Reference model state
    logic [POS_W-1:0] m_pos;
    logic             m_dir, m_step, m_energ, m_fault, m_ref;
    logic [1:0]       m_code, m_prev;
    logic [3:0]       hist[$];
    int               m_idle;
    logic             m_stall;

    function automatic logic [3:0] drv(input logic [1:0] ph);
        return {ph[1], ~ph[1], ph[0], ~ph[0]};
    endfunction

    task automatic model_reset();
        m_pos = '0; m_dir = 0; m_step = 0; m_energ = 0; m_fault = 0; m_ref = 0;
        m_code = 2'b00; m_prev = 2'b00; m_idle = 0; m_stall = 0;
        hist.delete();
        for (int i = 0; i < int'(NS); i++) hist.push_back(4'b0000);
    endtask

    task automatic model_edge(input logic [3:0] d, input logic c);
        logic [3:0] s;
        logic [1:0] ph;
        int         dd;
        if (c || m_step || !m_energ) m_idle = 0;
        else if (m_idle < int'(STALL_CYC)) m_idle = m_idle + 1;
        m_stall = (m_idle >= int'(STALL_CYC));
        hist.push_back(d);
        s  = hist.pop_front();
        ph = {s[3], s[1]};
        m_step = 0;
        if (s == 4'b0000) begin
            m_energ = 0; m_ref = 0;
        end else if ((s[3] != s[2]) && (s[1] != s[0])) begin
            m_energ = 1;
            if (m_ref) begin
                dd = (gi[ph] - gi[m_prev] + 4) % 4;
                if (dd == 1 && !c) begin m_pos = m_pos + 1'b1; m_dir = 1; m_step = 1; end
                if (dd == 3 && !c) begin m_pos = m_pos - 1'b1; m_dir = 0; m_step = 1; end
                if (dd == 2) begin
                    if (!m_fault) m_code = 2'b01;
                    m_fault = 1;
                end
            end
            m_prev = ph; m_ref = 1;
        end else begin
            m_energ = 0; m_ref = 0;
            if (!m_fault) m_code = 2'b10;
            m_fault = 1;
        end
        if (c) begin m_pos = '0; m_fault = 0; m_code = 2'b00; end
    endtask

    task automatic tick(input logic [3:0] d, input logic c);
        {a, an, b, bn} = d;
        clr = c;
        @(posedge clk);
        model_edge(d, c);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; {a, an, b, bn} = 4'b0000; clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int st = 0;
        do_reset();
        repeat (4) tick(drv(2'b00), 0);
        for (int i = 1; i <= 5; i++) tick(drv(fwd_seq[i % 4]), 0);
        repeat (3) tick(drv(fwd_seq[1]), 0);
        // async assertion mid-motion
        #2 rst = 1'b1;
        #1;
        n_tests++; if (pos !== '0) begin n_fail++; $display("FAIL reset_pos got=%h exp=0", pos); end
        n_tests++; if ({dir, step, energised, fault} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {dir, step, energised, fault}); end
        n_tests++; if (fault_code !== 2'b00) begin n_fail++; $display("FAIL reset_code got=%b exp=00", fault_code); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < int'(NS) + 2; i++) begin
            tick(drv(fwd_seq[1]), 0);
            if (step === 1'b1) st++;
        end
        n_tests++; if (st !== 0 || pos !== '0) begin n_fail++; $display("FAIL reset_ref_only steps=%0d pos=%h exp 0/0", st, pos); end
        repeat (4) tick(drv(fwd_seq[2]), 0);
        n_tests++; if (pos !== POS_W'(1) || dir !== 1'b1) begin n_fail++; $display("FAIL reset_first_step pos=%h dir=%b exp 1/1", pos, dir); end
    endtask

    task automatic test_hold();
        int st = 0;
        do_reset();
        for (int k = 1; k <= int'(NS) + 1; k++) begin
            tick(4'b1010, 0);
            if (k == int'(NS)) begin
                n_tests++; if (energised !== 1'b0) begin n_fail++; $display("FAIL hold_early_energ got=%b exp=0", energised); end
            end
        end
        n_tests++; if (energised !== 1'b1) begin n_fail++; $display("FAIL hold_energ got=%b exp=1", energised); end
        repeat (6) begin
            tick(4'b1010, 0);
            if (step !== 1'b0) st++;
        end
        n_tests++; if (st !== 0 || pos !== '0) begin n_fail++; $display("FAIL hold_nostep steps=%0d pos=%h exp 0/0", st, pos); end
    endtask

    task automatic test_fwd_rev();
        int st = 0;
        do_reset();
        repeat (4) tick(drv(2'b00), 0);
        for (int i = 1; i <= 8; i++) repeat (4) begin
            tick(drv(fwd_seq[i % 4]), 0);
            if (step === 1'b1) st++;
        end
        n_tests++; if (st !== 8) begin n_fail++; $display("FAIL fwd_strobes got=%0d exp=8", st); end
        n_tests++; if (pos !== POS_W'(8) || dir !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL fwd_state pos=%h dir=%b fault=%b exp 8/1/0", pos, dir, fault); end
        for (int i = 1; i <= 3; i++) repeat (4) tick(drv(fwd_seq[(8 - i) % 4]), 0);
        n_tests++; if (pos !== POS_W'(5) || dir !== 1'b0) begin n_fail++; $display("FAIL rev_state pos=%h dir=%b exp 5/0", pos, dir); end
    endtask

    task automatic test_illegal();
        do_reset();
        repeat (4) tick(drv(2'b10), 0);
        repeat (4) tick(drv(2'b01), 0);
        n_tests++; if (fault !== 1'b1 || fault_code !== 2'b01 || pos !== '0) begin n_fail++; $display("FAIL illegal_first fault=%b code=%b pos=%h exp 1/01/0", fault, fault_code, pos); end
        repeat (4) tick(drv(2'b10), 0);
        n_tests++; if (fault_code !== 2'b01) begin n_fail++; $display("FAIL illegal_second code=%b exp=01", fault_code); end
        repeat (4) tick(4'b1111, 0);
        n_tests++; if (fault_code !== 2'b01 || energised !== 1'b0) begin n_fail++; $display("FAIL illegal_then_pair code=%b energ=%b exp 01/0", fault_code, energised); end
        repeat (4) tick(drv(2'b10), 0);
        tick(drv(2'b10), 1);
        n_tests++; if (fault !== 1'b0 || fault_code !== 2'b00 || pos !== '0) begin n_fail++; $display("FAIL illegal_clr fault=%b code=%b pos=%h exp 0/00/0", fault, fault_code, pos); end
    endtask

    task automatic test_pair_error();
        int st = 0;
        do_reset();
        repeat (4) tick(drv(2'b10), 0);
        repeat (4) tick(4'b1110, 0);
        n_tests++; if (fault_code !== 2'b10 || energised !== 1'b0 || fault !== 1'b1) begin n_fail++; $display("FAIL pair_code code=%b energ=%b fault=%b exp 10/0/1", fault_code, energised, fault); end
        repeat (5) begin
            tick(drv(2'b10), 0);
            if (step === 1'b1) st++;
        end
        n_tests++; if (st !== 0 || pos !== '0 || energised !== 1'b1) begin n_fail++; $display("FAIL pair_restore steps=%0d pos=%h energ=%b exp 0/0/1", st, pos, energised); end
        repeat (4) tick(drv(2'b11), 0);
        n_tests++; if (pos !== POS_W'(1) || dir !== 1'b1) begin n_fail++; $display("FAIL pair_next pos=%h dir=%b exp 1/1", pos, dir); end
        repeat (4) tick(drv(2'b10), 0);
        n_tests++; if (pos !== '0 || dir !== 1'b0) begin n_fail++; $display("FAIL pair_back pos=%h dir=%b exp 0/0", pos, dir); end
    endtask

    task automatic test_wrap_clr();
        int st = 0;
        do_reset();
        repeat (4) tick(drv(2'b00), 0);
        for (int i = 1; i <= 32767; i++) tick(drv(fwd_seq[i % 4]), 0);
        repeat (NS + 1) tick(drv(fwd_seq[3]), 0);
        n_tests++; if (pos !== 16'h7FFF) begin n_fail++; $display("FAIL wrap_preload got=%h exp=7fff", pos); end
        repeat (4) tick(drv(fwd_seq[0]), 0);
        n_tests++; if (pos !== 16'h8000) begin n_fail++; $display("FAIL wrap_pos got=%h exp=8000", pos); end
        // clr lands on the very edge the new phase reaches the decoder
        tick(drv(fwd_seq[1]), 0);
        repeat (NS - 1) tick(drv(fwd_seq[1]), 0);
        tick(drv(fwd_seq[1]), 1);
        n_tests++; if (pos !== '0 || step !== 1'b0) begin n_fail++; $display("FAIL clr_step pos=%h step=%b exp 0/0", pos, step); end
        repeat (3) begin
            tick(drv(fwd_seq[1]), 0);
            if (step === 1'b1) st++;
        end
        n_tests++; if (st !== 0) begin n_fail++; $display("FAIL clr_step_late steps=%0d exp=0", st); end
        repeat (4) tick(drv(fwd_seq[0]), 0);
        n_tests++; if (pos !== 16'hFFFF || dir !== 1'b0) begin n_fail++; $display("FAIL wrap_neg pos=%h dir=%b exp ffff/0", pos, dir); end
    endtask

    task automatic test_random();
        logic [1:0] cur = 2'b00;
        logic [3:0] d;
        logic       c;
        int         r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      begin cur = fwd_seq[(gi[cur] + 1) % 4]; d = drv(cur); end
            else if (r < 60) begin cur = fwd_seq[(gi[cur] + 3) % 4]; d = drv(cur); end
            else if (r < 75) d = drv(cur);
            else if (r < 82) begin cur = cur ^ 2'b11; d = drv(cur); end
            else if (r < 92) d = 4'($urandom);
            else             d = 4'b0000;
            c = ($urandom_range(0, 24) == 0);
            tick(d, c);
            n_tests++; if (pos !== m_pos) begin n_fail++; $display("FAIL rand_pos n=%0d got=%h exp=%h", n, pos, m_pos); end
            n_tests++; if ({dir, step, energised} !== {m_dir, m_step, m_energ}) begin n_fail++; $display("FAIL rand_flags n=%0d got=%b exp=%b", n, {dir, step, energised}, {m_dir, m_step, m_energ}); end
            n_tests++; if ({fault, fault_code} !== {m_fault, m_code}) begin n_fail++; $display("FAIL rand_fault n=%0d got=%b exp=%b", n, {fault, fault_code}, {m_fault, m_code}); end
`ifdef STEP_PHASE_STALL_DETECT_EN
            n_tests++; if (stall !== m_stall) begin n_fail++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall, m_stall); end
`endif
        end
    endtask

`ifdef STEP_PHASE_STALL_DETECT_EN
    task automatic test_stall();
        int first_en = -1;
        int first_st = -1;
        int k = 0;
        logic seen = 0;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            tick(drv(2'b10), 0);
            if (energised === 1'b1 && first_en < 0) first_en = n;
            if (stall === 1'b1 && first_st < 0) first_st = n;
            n_tests++; if (stall !== m_stall) begin n_fail++; $display("FAIL stall_hold n=%0d got=%b exp=%b", n, stall, m_stall); end
        end
        n_tests++; if (first_st - first_en !== int'(STALL_CYC)) begin n_fail++; $display("FAIL stall_delay got=%0d exp=%0d", first_st - first_en, STALL_CYC); end
        while (!seen && k < 8) begin
            tick(drv(2'b11), 0);
            seen = (step === 1'b1);
            k++;
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL stall_step_timeout got=no_step exp=step"); end
        tick(drv(2'b11), 0);
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_drop got=%b exp=0", stall); end
    endtask
`endif

    initial begin
        rst = 1'b1; clr = 1'b0; {a, an, b, bn} = 4'b0000;
        model_reset();
        #3;
        n_tests++; if (pos !== '0 || energised !== 1'b0 || fault_code !== 2'b00) begin n_fail++; $display("FAIL powerup pos=%h energ=%b code=%b exp 0/0/00", pos, energised, fault_code); end
        test_reset();
        test_hold();
        test_fwd_rev();
        test_illegal();
        test_pair_error();
        test_wrap_clr();
        test_random();
`ifdef STEP_PHASE_STALL_DETECT_EN
        test_stall();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/step_phase_decoder.md
Name: step_phase_decoder

Overview:
- Receive-side counterpart of the StepMotor phase generator: monitors the four coil-drive lines A, AN, B, BN and reconstructs motion.
- Validates complementary pairs, decodes full-step Gray sequence into a signed position count, direction and step strobe.
- Flags illegal transitions and pair faults.
- Sits next to the motor driver as a closed-loop check / position tracker for the controller.

Parameters:
- POS_W, 16, width of position counter (two's complement, wraps).
- SYNC_STAGES, 2, input synchronizer depth (min 1).
- STALL_CYC, 1024, idle cycles while energised before STALL asserts (optional feature only).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- A  in  1  phase A drive.
- AN  in  1  phase A complement.
- B  in  1  phase B drive.
- BN  in  1  phase B complement.
- CLR  in  1  synchronous clear of POS, FAULT, FAULT_CODE, STALL.
- POS  out  POS_W  signed step count.
- DIR  out  1  direction of last counted step, 1 = forward.
- STEP  out  1  one-cycle strobe per counted step.
- ENERGISED  out  1  both pairs currently valid complementary.
- FAULT  out  1  sticky fault flag.
- FAULT_CODE  out  2  first fault cause: 00 none, 01 illegal transition, 10 pair error.

Behaviour:
- Reset (async, RST=1): POS=0, DIR=0, STEP=0, ENERGISED=0, FAULT=0, FAULT_CODE=00, sync flops=0, ref_valid=0.
- Inputs pass through SYNC_STAGES flops; then a one-cycle classification stage. Latency: input change to STEP/POS update = SYNC_STAGES+1 cycles.
- Pair classification per synchronized sample:
  - Both pairs 00: de-energised. ENERGISED=0, ref_valid cleared, no fault.
  - Both pairs complementary: valid. ENERGISED=1, phase code = {A,B}.
  - Any other combination (a pair at 11, or one pair 00 with the other valid): pair error.
- Forward sequence: 00->10->11->01->00. Reverse is the inverse.
- Counting, when valid and ref_valid=1, compared with the previous phase:
  - Same phase: no action.
  - Forward neighbour: POS+1, DIR=1, STEP=1.
  - Reverse neighbour: POS-1, DIR=0, STEP=1.
  - Two-bit change: illegal transition. POS unchanged, no STEP.
- First valid sample with ref_valid=0: latches the phase as reference and sets ref_valid=1. No step is counted.
- Pair error: POS held, ref_valid cleared, ENERGISED=0.
- Every valid sample updates the previous-phase register, including after an illegal transition.
- FAULT:
  - Set on illegal transition or pair error.
  - FAULT_CODE records only the first cause; later faults do not overwrite it.
  - Sticky until CLR or RST.
- CLR=1 (synchronous, highest priority after RST):
  - POS=0, FAULT=0, FAULT_CODE=00, STEP=0.
  - The previous-phase register still loads the current valid sample, so the next neighbour counts normally.
- CLR coincident with a step: CLR wins; the step is not counted.
- POS wraps modulo 2^POS_W: 0x7FFF+1 -> 0x8000 and 0x0000-1 -> 0xFFFF at default width.
- RST mid-motion: all state cleared. The first valid sample after release is reference only.

Optional Feature:
- Macro: STEP_PHASE_STALL_DETECT_EN.
- Enabled:
  - Adds output STALL (1 bit, reset 0) and an idle counter that counts cycles with ENERGISED=1 and no STEP.
  - Counter clears on STEP, on de-energise, or on CLR, and saturates.
  - STALL=1 while the counter is >= STALL_CYC; it drops the cycle after a STEP or CLR.
- Disabled: no STALL port and no counter; all other behaviour is identical.

Test Plan:
- RST pulse, then drive A/AN/B/BN = 1010 (phase 11) held -> POS=0, ENERGISED=1 after SYNC_STAGES+1 cycles, STEP never asserts.
- From phase 00, drive 8 forward steps (00,10,11,01,...), each held 4 cycles -> 8 single-cycle STEP pulses, POS=8, DIR=1, FAULT=0. Then 3 reverse steps -> POS=5, DIR=0.
- Jump phase 10->01 -> FAULT=1, FAULT_CODE=01, POS unchanged. Next jump from the new phase 01 -> code still 01. Then drive a pair error -> code still 01 (first cause retained). Pulse CLR -> FAULT=0, code=00, POS=0.
- Drive A=AN=1 -> FAULT_CODE=10, ENERGISED=0. Restore valid phase -> no STEP on the first valid sample; the next neighbour counts +/-1.
- Preload POS to 0x7FFF via 32767 forward steps, then one more step -> POS=0x8000. CLR in the same cycle as a step edge -> POS=0, no STEP.
- With STEP_PHASE_STALL_DETECT_EN and STALL_CYC=16, hold valid phase 20 cycles -> STALL=1 from the 16th idle cycle. Issue one step -> STALL=0 the following cycle.
